// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT: bit-reversed load, one butterfly per clock
// with 1/2 scaling per stage, natural-order readout over a valid/ready stream.
module fft_r2_iter #(
    parameter int DW    = 8,
    parameter int LOG2N = 3,
    parameter int TW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    in_re,
    input  logic signed [DW-1:0]    in_im,
    input  logic                    inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DW-1:0]    out_re,
    output logic signed [DW-1:0]    out_im,
    output logic [LOG2N-1:0]        out_idx,
    output logic                    out_last,
    output logic                    busy
);
    localparam int  N     = 1 << LOG2N;
    localparam int  HN    = N / 2;
    localparam int  KW    = LOG2N - 1;
    localparam int  SW    = $clog2(LOG2N);
    localparam int  EW    = DW + 2;
    localparam int  PW    = DW + TW + 1;
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = real'((1 << (TW - 1)) - 1);

    localparam logic [LOG2N-1:0]     ONE      = LOG2N'(1);
    localparam logic [SW-1:0]        LAST_STG = SW'(LOG2N - 1);
    localparam logic signed [EW-1:0] SAT_MAX  = EW'((1 << (DW - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [EW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DW-1:0];
        if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

    // Twiddle ROM, W^k = exp(-j*2*pi*k/N) in Q1.(TW-1), rounded to nearest.
    logic signed [TW-1:0] rom_re [HN];
    logic signed [TW-1:0] rom_im [HN];

    for (genvar g = 0; g < HN; g++) begin : g_rom
        localparam real ANG = 2.0 * PI * real'(g) / real'(N);
        localparam real CR  = SCALE * $cos(ANG);
        localparam real SR  = SCALE * $sin(ANG);
        localparam int  WRE = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  WIM = (SR >= 0.0) ? -$rtoi(SR + 0.5) : $rtoi(0.5 - SR);
        assign rom_re[g] = TW'(WRE);
        assign rom_im[g] = TW'(WIM);
    end

    state_t               state_q, state_d;
    logic [LOG2N-1:0]     ld_cnt_q, ld_cnt_d;
    logic [KW-1:0]        bf_q, bf_d;
    logic [SW-1:0]        stg_q, stg_d;
    logic [LOG2N-1:0]     oidx_q, oidx_d;
    logic                 inv_q, inv_d;
    logic signed [DW-1:0] mem_re_q [N];
    logic signed [DW-1:0] mem_im_q [N];

    // Butterfly addressing: group base = (bf / span) * 2 * span, offset j = bf mod span.
    logic [LOG2N-1:0] span, jpos, grp, addr_a, addr_b;
    logic [KW-1:0]    tw_k;

    always_comb begin
        span   = ONE << stg_q;
        jpos   = LOG2N'(bf_q) & (span - ONE);
        grp    = LOG2N'(bf_q) >> stg_q;
        addr_a = ((grp << 1) << stg_q) | jpos;
        addr_b = addr_a | span;
        tw_k   = KW'(jpos << (LAST_STG - stg_q));
    end

    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [PW-1:0] p_re, p_im;
    logic signed [EW-1:0] t_re, t_im;
    logic signed [DW-1:0] ap_re, ap_im, bp_re, bp_im;

    always_comb begin
        a_re = mem_re_q[addr_a];
        a_im = mem_im_q[addr_a];
        b_re = mem_re_q[addr_b];
        b_im = mem_im_q[addr_b];
        w_re = rom_re[tw_k];
        w_im = inv_q ? -rom_im[tw_k] : rom_im[tw_k];
        p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        // W^0 is exactly 1, so skip the lossy Q-format multiply there.
        if (tw_k == '0) begin
            t_re = EW'(b_re);
            t_im = EW'(b_im);
        end else begin
            t_re = EW'(p_re >>> (TW - 1));
            t_im = EW'(p_im >>> (TW - 1));
        end
        ap_re = sat((EW'(a_re) + t_re) >>> 1);
        ap_im = sat((EW'(a_im) + t_im) >>> 1);
        bp_re = sat((EW'(a_re) - t_re) >>> 1);
        bp_im = sat((EW'(a_im) - t_im) >>> 1);
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) begin
            mem_re_q[bitrev(ld_cnt_q)] <= in_re;
            mem_im_q[bitrev(ld_cnt_q)] <= in_im;
        end else if (state_q == S_CALC) begin
            mem_re_q[addr_a] <= ap_re;
            mem_im_q[addr_a] <= ap_im;
            mem_re_q[addr_b] <= bp_re;
            mem_im_q[addr_b] <= bp_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            ld_cnt_q <= '0;
            bf_q     <= '0;
            stg_q    <= '0;
            oidx_q   <= '0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            bf_q     <= bf_d;
            stg_q    <= stg_d;
            oidx_q   <= oidx_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        bf_d     = bf_q;
        stg_d    = stg_q;
        oidx_d   = oidx_q;
        inv_d    = inv_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    ld_cnt_d = ld_cnt_q + ONE;
                    if (ld_cnt_q == '0) inv_d = inv;
                    if (&ld_cnt_q) state_d = S_CALC;
                end
            end
            S_CALC: begin
                bf_d = bf_q + KW'(1);
                if (&bf_q) begin
                    if (stg_q == LAST_STG) begin
                        stg_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        stg_d = stg_q + SW'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    oidx_d = oidx_q + ONE;
                    if (&oidx_q) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        busy      = (state_q == S_CALC);
        out_valid = (state_q == S_OUT);
        out_re    = '0;
        out_im    = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_re   = mem_re_q[oidx_q];
            out_im   = mem_im_q[oidx_q];
            out_idx  = oidx_q;
            out_last = &oidx_q;
        end
    end

endmodule

// File: tb/tb_fft_r2_iter.sv
// Directed bench for fft_r2_iter at N=8: impulses, forward/inverse, gaps, backpressure,
// full-scale input and mid-CALC reset, all against hand-computed bins.
module tb_fft_r2_iter;
    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, inv, out_valid, out_ready, out_last, busy;
    logic signed [7:0] in_re, in_im, out_re, out_im;
    logic [2:0]        out_idx;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] xr [8];
    logic signed [7:0] xi [8];
    logic signed [7:0] er [8];
    logic signed [7:0] ei [8];
    logic signed [7:0] got_re [8];
    logic signed [7:0] got_im [8];
    logic [2:0]        got_idx [8];
    logic              got_last [8];
    int                lat;
    logic              busy_at_last, busy_at_out, rdy_after;

    fft_r2_iter #(.DW(8), .LOG2N(3), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_x();
        for (int i = 0; i < 8; i++) begin
            xr[i] = 8'sd0; xi[i] = 8'sd0; er[i] = 8'sd0; ei[i] = 8'sd0;
        end
    endtask

    task automatic set_exp(input int b, input logic signed [7:0] re, input logic signed [7:0] im);
        er[b] = re;
        ei[b] = im;
    endtask

    // inv is flipped on beats 1..7 so that only the beat-0 value may take effect.
    task automatic send_frame(input logic inv_b, input logic gaps);
        int g;
        for (int n = 0; n < 8; n++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) tick();
            end
            in_valid = 1'b1;
            in_re    = xr[n];
            in_im    = xi[n];
            inv      = (n == 0) ? inv_b : ~inv_b;
            tick();
        end
        in_valid     = 1'b0;
        inv          = 1'b0;
        busy_at_last = busy;
    endtask

    task automatic collect();
        int guard;
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            guard = 0;
            while (!out_valid && guard < 100) begin
                tick();
                guard++;
            end
            got_re[b]   = out_re;
            got_im[b]   = out_im;
            got_idx[b]  = out_idx;
            got_last[b] = out_last;
            tick();
        end
        rdy_after = in_ready;
    endtask

    task automatic run_frame(input logic inv_b, input logic gaps);
        send_frame(inv_b, gaps);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        busy_at_out = busy;
        collect();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_re = 8'sd0; in_im = 8'sd0; inv = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        checks++; if ({out_re, out_im, out_idx} !== 19'd0) begin
            errors++; $display("FAIL reset outputs got re=%0d im=%0d idx=%0d want 0", out_re, out_im, out_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_impulse();
        clear_x();
        xr[0] = 8'sd64;
        for (int b = 0; b < 8; b++) set_exp(b, 8'sd8, 8'sd0);
        run_frame(1'b0, 1'b0);
        checks++; if (busy_at_last !== 1'b1) begin errors++; $display("FAIL impulse busy_after_last got %b want 1", busy_at_last); end
        checks++; if (lat !== 12) begin errors++; $display("FAIL impulse latency got %0d want 12", lat); end
        checks++; if (busy_at_out !== 1'b0) begin errors++; $display("FAIL impulse busy_at_out got %b want 0", busy_at_out); end
        checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL impulse in_ready_after got %b want 1", rdy_after); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL impulse re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL impulse im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
            checks++; if (got_idx[b] !== 3'(b)) begin errors++; $display("FAIL impulse idx[%0d] got %0d want %0d", b, got_idx[b], b); end
            checks++; if (got_last[b] !== (b == 7)) begin errors++; $display("FAIL impulse last[%0d] got %b want %b", b, got_last[b], b == 7); end
        end
    endtask

    task automatic test_shifted_impulse();
        clear_x();
        xr[4] = 8'sd64;
        for (int b = 0; b < 8; b++) set_exp(b, (b % 2 == 0) ? 8'sd8 : -8'sd8, 8'sd0);
        run_frame(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL shifted re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL shifted im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
        end
    endtask

    task automatic test_fwd_inv();
        clear_x();
        xr[2] = 8'sd64;
        set_exp(0, 8'sd8, 8'sd0); set_exp(1, 8'sd0, -8'sd8); set_exp(2, -8'sd8, 8'sd0); set_exp(3, 8'sd0, 8'sd8);
        for (int b = 4; b < 8; b++) set_exp(b, er[b-4], ei[b-4]);
        run_frame(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL forward re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL forward im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
        end
        set_exp(0, 8'sd8, 8'sd0); set_exp(1, 8'sd0, 8'sd7); set_exp(2, -8'sd8, 8'sd0); set_exp(3, 8'sd0, -8'sd8);
        for (int b = 4; b < 8; b++) set_exp(b, er[b-4], ei[b-4]);
        run_frame(1'b1, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL inverse re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL inverse im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
        end
    endtask

    task automatic test_constant();
        clear_x();
        for (int i = 0; i < 8; i++) xr[i] = 8'sd16;
        set_exp(0, 8'sd16, 8'sd0);
        for (int pass = 0; pass < 2; pass++) begin
            run_frame(1'b0, pass == 1);
            for (int b = 0; b < 8; b++) begin
                checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL constant%0d re[%0d] got %0d want %0d", pass, b, got_re[b], er[b]); end
                checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL constant%0d im[%0d] got %0d want %0d", pass, b, got_im[b], ei[b]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int   phase = 0;
        int   stall = 0;
        int   guard = 0;
        int   delivered [8];
        logic rdy = 1'b1;
        logic prev_stall = 1'b0;
        logic done = 1'b0;
        logic signed [7:0] pre_re, pre_im;
        logic [2:0] pre_idx;
        pre_re = 8'sd0; pre_im = 8'sd0; pre_idx = 3'd0;
        clear_x();
        xr[2] = 8'sd64;
        set_exp(0, 8'sd8, 8'sd0); set_exp(1, 8'sd0, -8'sd8); set_exp(2, -8'sd8, 8'sd0); set_exp(3, 8'sd0, 8'sd8);
        for (int b = 4; b < 8; b++) set_exp(b, er[b-4], ei[b-4]);
        for (int b = 0; b < 8; b++) delivered[b] = 0;
        send_frame(1'b0, 1'b0);
        while (!done && guard < 200) begin
            if (out_valid) begin
                if (prev_stall) begin
                    checks++;
                    if ({out_re, out_im, out_idx} !== {pre_re, pre_im, pre_idx}) begin
                        errors++; $display("FAIL bp stable got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                                           out_re, out_im, out_idx, pre_re, pre_im, pre_idx);
                    end
                end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready_during_out got %b want 0", in_ready); end
                if (phase == 0 && out_idx == 3'd2) begin
                    phase = 1;
                    stall = 3;
                end
                if (phase == 1) begin
                    if (stall > 0) begin
                        rdy = 1'b0;
                        stall--;
                    end else begin
                        phase = 2;
                        rdy = 1'b1;
                    end
                end else if (phase == 2) begin
                    rdy = ~rdy;
                end else begin
                    rdy = 1'b1;
                end
                out_ready = rdy;
                if (rdy) begin
                    delivered[out_idx]++;
                    checks++; if (out_re !== er[out_idx]) begin errors++; $display("FAIL bp re[%0d] got %0d want %0d", out_idx, out_re, er[out_idx]); end
                    checks++; if (out_im !== ei[out_idx]) begin errors++; $display("FAIL bp im[%0d] got %0d want %0d", out_idx, out_im, ei[out_idx]); end
                    if (out_last) done = 1'b1;
                end
                prev_stall = ~rdy;
                pre_re = out_re; pre_im = out_im; pre_idx = out_idx;
            end
            tick();
            guard++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp timeout got done=%b want 1", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready_after got %b want 1", in_ready); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (delivered[b] !== 1) begin errors++; $display("FAIL bp deliveries[%0d] got %0d want 1", b, delivered[b]); end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        clear_x();
        for (int i = 0; i < 8; i++) begin xr[i] = 8'sd127; xi[i] = 8'sd127; end
        set_exp(0, 8'sd127, 8'sd127);
        run_frame(1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL fullscale re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL fullscale im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
        end
    endtask

    task automatic test_reset_mid_calc();
        clear_x();
        xr[3] = 8'sd100;
        xi[5] = -8'sd50;
        send_frame(1'b0, 1'b0);
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst busy_before got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL midrst out_idx got %0d want 0", out_idx); end
        clear_x();
        xr[0] = 8'sd64;
        for (int b = 0; b < 8; b++) set_exp(b, 8'sd8, 8'sd0);
        run_frame(1'b0, 1'b0);
        checks++; if (lat !== 12) begin errors++; $display("FAIL midrst latency got %0d want 12", lat); end
        for (int b = 0; b < 8; b++) begin
            checks++; if (got_re[b] !== er[b]) begin errors++; $display("FAIL midrst re[%0d] got %0d want %0d", b, got_re[b], er[b]); end
            checks++; if (got_im[b] !== ei[b]) begin errors++; $display("FAIL midrst im[%0d] got %0d want %0d", b, got_im[b], ei[b]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_shifted_impulse();
        test_fwd_inv();
        test_constant();
        test_backpressure();
        test_saturation();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_r2_iter.md
# fft_r2_iter

Parametrised iterative radix-2 DIT FFT/IFFT core, the next generation of the team's fixed 8-point `pfft` datapath. The core accepts N = 2^LOG2N complex samples over a valid/ready stream and stores them bit-reversed. It computes in place with a single butterfly, one butterfly per clock, scaling by 1/2 every stage, and streams the N results out in natural order. It also supports a per-frame inverse mode. It sits between the sample-capture front end and spectral post-processing.

## Interface
- `DW`, default 8: signed data width of real and imaginary parts.
- `LOG2N`, default 3: log2 of the transform size. Legal range is 2..6.
- `TW`, default 8: signed twiddle width, format Q1.(TW-1).
- `clk`  in  1: the single clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `in_valid`  in  1: input sample valid.
- `in_ready`  out  1: the core can accept a sample.
- `in_re`, `in_im`  in  DW: input sample, two's complement.
- `inv`  in  1: inverse-transform select. Sampled on the first accepted beat of a frame.
- `out_valid`  out  1: output sample valid.
- `out_ready`  in  1: downstream accepts the output sample.
- `out_re`, `out_im`  out  DW: output bin.
- `out_idx`  out  LOG2N: bin index of the current output.
- `out_last`  out  1: high with bin N-1.
- `busy`  out  1: high in CALC.

## Operation
- FSM states: LOAD → CALC → OUT → LOAD.
- **LOAD**
  - `in_ready`=1.
  - Beat n (0..N-1) is accepted when `in_valid`&&`in_ready`; the sample is written to mem[bitrev(n)].
  - `inv` is latched on beat 0.
  - After beat N-1 the FSM enters CALC.
- **CALC**
  - Stages s = 0..LOG2N-1, span = 2^s. There are N/2 butterflies per stage.
  - Each butterfly pairs indices (p, p+span) within groups of 2·span, with group position j in 0..span-1.
  - Twiddle index k = j·N/(2·span).
  - Per butterfly: A = mem[p], B = mem[p+span], both read combinationally. A' and B' are written back at the same clock edge.
- **Twiddle ROM**
  - Built at elaboration: W.re = round(cos(2πk/N)·(2^(TW-1)-1)), W.im = −round(sin(2πk/N)·(2^(TW-1)-1)), for k = 0..N/2-1.
  - When the latched `inv`=1, W.im is negated.
- **Butterfly arithmetic**
  - If k=0: t = B exactly (multiplier bypassed).
  - Otherwise: t.re = (B.re·W.re − B.im·W.im) >>> (TW-1), and t.im = (B.re·W.im + B.im·W.re) >>> (TW-1). These are full-precision signed products; the arithmetic shift floors.
  - A' = (A + t) >>> 1 and B' = (A − t) >>> 1, computed at DW+2 bits.
  - A' and B' are saturated to [−2^(DW-1), 2^(DW-1)−1].
  - Net transform result = DFT/N (forward) or IDFT·1/N (inverse).
- **OUT**
  - `out_valid`=1, `out_re`/`out_im` = mem[out_idx], with `out_idx` counting 0..N-1.
  - The index advances only on `out_valid`&&`out_ready`. Data and index stay stable while stalled.
  - The handshake with `out_last`=1 returns the FSM to LOAD.
- When `out_valid`=0: `out_re`, `out_im`, `out_idx` and `out_last` are 0.
- `in_valid` is ignored outside LOAD.
- `out_ready` is ignored outside OUT.

## Timing
- **Reset** (first edge with `rst`=1): FSM in LOAD with all counters zero.
  - Output values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `out_re`=`out_im`=`out_idx`=0.
  - Memory is not cleared and is never output before being overwritten.
- **`rst` mid-frame** (in LOAD, CALC or OUT): the partial frame is discarded, with the same state as after reset.
- **Load rate:** one sample per cycle at full rate. Gaps in `in_valid` only stretch LOAD.
- **CALC length:** exactly B = LOG2N·N/2 cycles (12 for N=8).
  - `busy` rises on the edge accepting beat N-1 and falls B edges later.
  - `out_valid` rises on that same edge, i.e. B edges after the last input accept.
- **Output rate:** N cycles minimum with `out_ready` held high.
- **Frame turnaround:** `in_ready` returns to 1 on the edge of the final output handshake.
- **Frame period:** minimum 2N+B cycles (28 for N=8). Frames never overlap.

## Test plan
- **Impulse:** N=8, forward, x[0]=64+0j, others 0 → all 8 bins out_re=8, out_im=0. `out_last` is high only at idx 7. `out_valid` rises 12 edges after the last input accept.
- **Shifted impulse:** x[4]=64 → out_re = 8,−8,8,−8,8,−8,8,−8, out_im all 0.
- **Forward vs inverse:**
  - x[2]=64, forward → bins 0..3 = (8,0),(0,−8),(−8,0),(0,8); bins 4..7 repeat them.
  - Same input with `inv`=1 → bins 0..3 = (8,0),(0,7),(−8,0),(0,−8). This checks twiddle conjugation and the floor rule.
- **Constant input:** all samples 16+0j → bin 0 = 16, all other bins 0. Then:
  - Stimulus: random `in_valid` gaps.
  - Required response: same result.
- **Backpressure:** `out_ready` low for 3 cycles at idx 2, then toggled every cycle → `out_re`/`out_im`/`out_idx` stable while stalled, each bin delivered exactly once, `in_ready` low until the idx-7 handshake.
- **Saturation and reset:**
  - Full-scale input (all samples 127+127j) → no wraparound: results are saturated, bin 0 = (127,127), all other bins (0,0).
  - `rst` pulsed in mid-CALC → next edge shows `busy`=0, `in_ready`=1, `out_valid`=0. A fresh impulse frame then gives the correct result.
